// File: rtl/pipe_pkg.sv
// Shared types and register-index constants for the pipelined core's GPR file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  // Register file life cycle: sweep-initialise the storage, then normal operation.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } regfile_state_e;

  // Architectural register indices with special meaning.
  localparam int REG_ZERO = 0;   // hardwired zero
  localparam int REG_SP   = 29;  // stack pointer, gets a non-zero reset value
  localparam int REG_EPC  = 26;  // exception PC backup target

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set when a producer issues, cleared when WB writes it.
// Latency: set/clear take effect at the next rising edge; lookups are combinational on the stored bits.
// Backpressure: none; the caller gates set/clear with its own enables.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset (clears every pending bit)
//   clr_en, clr_addr    WB write: clear the pending bit of clr_addr
//   set_en, set_addr    ID issue: set the pending bit of set_addr (wins over a clear to the same index)
//   look_addr_a/b       lookup indices for the two read ports
//   busy_a/b            stored pending bit of the looked-up index (index 0 always 0)
module regfile_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [ADDR_W-1:0] look_addr_a,
  input  logic [ADDR_W-1:0] look_addr_b,
  output logic              busy_a,
  output logic              busy_b
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] sb_q;
  logic [DEPTH-1:0] sb_d;

  always_comb begin
    sb_d = sb_q;
    for (int i = 1; i < DEPTH; i++) begin
      // Set is checked first: a producer issuing in ID the same cycle an older
      // producer retires in WB keeps the register pending.
      if (set_en && (set_addr == ADDR_W'(i))) begin
        sb_d[i] = 1'b1;
      end else if (clr_en && (clr_addr == ADDR_W'(i))) begin
        sb_d[i] = 1'b0;
      end
    end
    // $zero never has a producer.
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign busy_a = sb_q[look_addr_a];
  assign busy_b = sb_q[look_addr_b];

endmodule

// File: rtl/pipe_regfile.sv
// 2R/1W GPR file with WB->ID bypass, pending scoreboard, sweep init and an EPC backup write port.
// Latency: reads are combinational; writes land at the next rising edge (visible same cycle when BYPASS=1).
// Backpressure: none; while the init sweep runs ready=0 and all writes/scoreboard sets are dropped.
//
// Ports:
//   clk, reset             clock and synchronous active-high reset (restarts the init sweep)
//   ready                  1 once the init sweep has finished
//   rd_addr_a/b            read addresses from ID
//   rd_data_a/b            read data (combinational, bypassed when BYPASS=1)
//   rd_busy_a/b            register has an outstanding producer
//   wr_en/wr_addr/wr_data  WB write port
//   sb_set/sb_addr         mark a register pending when its producer issues
//   epc_en/epc_data        EPC backup write into EPC_IDX (wins over WB to the same index)
//   epc_q                  stored EPC_IDX contents, never bypassed
module pipe_regfile
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 5,
  parameter int                SP_IDX  = REG_SP,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'('h800),
  parameter int                EPC_IDX = REG_EPC,
  parameter bit                BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic              epc_en,
  input  logic [DATA_W-1:0] epc_data,
  output logic [DATA_W-1:0] epc_q
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] SP_A     = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] EPC_A    = ADDR_W'(EPC_IDX);

  // ---------------------------------------------------------------------------
  // Init FSM
  // ---------------------------------------------------------------------------
  regfile_state_e    state_q;
  regfile_state_e    state_d;
  logic [ADDR_W-1:0] idx_q;
  logic              ready_q;
  logic              init_we;
  logic              run_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      idx_q   <= IDX_ONE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == RUN);
      if (state_q == INIT) begin
        idx_q <= idx_q + IDX_ONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (idx_q == IDX_LAST) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Both enables are also gated by reset so a reset arriving mid-RUN blocks
  // that cycle's writes and blanks the read ports before the state flips.
  always_comb begin
    init_we = 1'b0;
    run_en  = 1'b0;
    case (state_q)
      INIT:    init_we = !reset;
      RUN:     run_en  = !reset;
      default: ;
    endcase
  end

  assign ready = ready_q;

  // ---------------------------------------------------------------------------
  // Storage: no reset on the array so it can map onto a RAM macro; the sweep
  // provides the initial contents instead. Entry 0 is never written.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] init_val;
  logic              wr_ok;
  logic              epc_ok;
  logic              wr_mem;
  logic              set_ok;

  assign init_val = (idx_q == SP_A) ? SP_INIT : '0;
  assign wr_ok    = run_en && wr_en && (wr_addr != '0);
  assign epc_ok   = run_en && epc_en;
  // EPC backup takes priority when both ports target the EPC register.
  assign wr_mem   = wr_ok && !(epc_ok && (wr_addr == EPC_A));
  assign set_ok   = run_en && sb_set && (sb_addr != '0);

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[idx_q] <= init_val;
    end else begin
      if (wr_mem) begin
        mem[wr_addr] <= wr_data;
      end
      if (epc_ok) begin
        mem[EPC_A] <= epc_data;
      end
    end
  end

  assign epc_q = mem[EPC_A];

  // ---------------------------------------------------------------------------
  // Read muxes
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data_a = mem[rd_addr_a];
    if (!run_en || (rd_addr_a == '0)) begin
      rd_data_a = '0;
    end else if (BYPASS && epc_ok && (rd_addr_a == EPC_A)) begin
      rd_data_a = epc_data;
    end else if (BYPASS && wr_ok && (rd_addr_a == wr_addr)) begin
      rd_data_a = wr_data;
    end
  end

  always_comb begin
    rd_data_b = mem[rd_addr_b];
    if (!run_en || (rd_addr_b == '0)) begin
      rd_data_b = '0;
    end else if (BYPASS && epc_ok && (rd_addr_b == EPC_A)) begin
      rd_data_b = epc_data;
    end else if (BYPASS && wr_ok && (rd_addr_b == wr_addr)) begin
      rd_data_b = wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and busy lookups
  // ---------------------------------------------------------------------------
  logic sb_busy_a;
  logic sb_busy_b;
  logic clr_now_a;
  logic clr_now_b;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .clr_en      (wr_ok),
    .clr_addr    (wr_addr),
    .set_en      (set_ok),
    .set_addr    (sb_addr),
    .look_addr_a (rd_addr_a),
    .look_addr_b (rd_addr_b),
    .busy_a      (sb_busy_a),
    .busy_b      (sb_busy_b)
  );

  // A clear only becomes effective when no set to the same index competes
  // with it, so only then may it be forwarded to the read port.
  assign clr_now_a = wr_ok && (wr_addr == rd_addr_a) && !(set_ok && (sb_addr == rd_addr_a));
  assign clr_now_b = wr_ok && (wr_addr == rd_addr_b) && !(set_ok && (sb_addr == rd_addr_b));

  assign rd_busy_a = run_en && (rd_addr_a != '0) && sb_busy_a && !(BYPASS && clr_now_a);
  assign rd_busy_b = run_en && (rd_addr_b != '0) && sb_busy_b && !(BYPASS && clr_now_b);

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: one BYPASS=1 and one BYPASS=0 instance on shared inputs.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, sb_addr;
  logic [31:0] wr_data, epc_data;
  logic        wr_en, sb_set, epc_en;

  logic        ready, rd_busy_a, rd_busy_b;
  logic [31:0] rd_data_a, rd_data_b, epc_q;
  logic        ready_0, rd_busy_a_0, rd_busy_b_0;
  logic [31:0] rd_data_a_0, rd_data_b_0, epc_q_0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_regfile #(.BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .epc_en(epc_en), .epc_data(epc_data), .epc_q(epc_q)
  );

  pipe_regfile #(.BYPASS(1'b0)) dut_0 (
    .clk(clk), .reset(reset), .ready(ready_0),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a_0), .rd_data_b(rd_data_b_0),
    .rd_busy_a(rd_busy_a_0), .rd_busy_b(rd_busy_b_0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .epc_en(epc_en), .epc_data(epc_data), .epc_q(epc_q_0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    sb_set   = 1'b0;
    sb_addr  = '0;
    epc_en   = 1'b0;
    epc_data = '0;
  endtask

  // Called just after the edge that sampled reset: 31 cycles of ready=0 with
  // blanked read ports, then ready=1.
  task automatic sweep(input string tag);
    for (int c = 0; c < 31; c++) begin
      chk({tag, "_ready"},   ready,     32'd0);
      chk({tag, "_ready0"},  ready_0,   32'd0);
      chk({tag, "_rd_a"},    rd_data_a, 32'd0);
      chk({tag, "_busy_b"},  rd_busy_b, 32'd0);
      cyc();
    end
    idle();
    #1;
    chk({tag, "_ready_up"},  ready,   32'd1);
    chk({tag, "_ready_up0"}, ready_0, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    rd_addr_a = 5'd29;
    rd_addr_b = 5'd26;
    cyc();
    reset = 1'b0;
    #1;

    // 1. init sweep and post-reset contents
    sweep("init");
    chk("r29_sp",    rd_data_a,   32'h800);
    chk("r29_sp0",   rd_data_a_0, 32'h800);
    chk("r26_zero",  rd_data_b,   32'h0);
    chk("epc_q_rst", epc_q,       32'h0);
    rd_addr_a = 5'd5; rd_addr_b = 5'd0;
    #1;
    chk("r5_zero",   rd_data_a,   32'h0);
    chk("r0_zero",   rd_data_b,   32'h0);
    chk("r0_busy",   rd_busy_b,   32'd0);

    // 2. write bypass
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF; rd_addr_a = 5'd7;
    #1;
    chk("byp_r7",      rd_data_a,   32'hDEAD_BEEF);
    chk("nobyp_r7",    rd_data_a_0, 32'h0);
    cyc(); idle(); #1;
    chk("r7_after",    rd_data_a,   32'hDEAD_BEEF);
    chk("r7_after0",   rd_data_a_0, 32'hDEAD_BEEF);

    // 3. $zero is immutable and never busy
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr_a = 5'd0;
    sb_set = 1'b1; sb_addr = 5'd0; rd_addr_b = 5'd0;
    #1;
    chk("r0_wr_comb",  rd_data_a,   32'h0);
    chk("r0_wr_comb0", rd_data_a_0, 32'h0);
    cyc(); idle(); #1;
    chk("r0_wr_next",  rd_data_a,   32'h0);
    chk("r0_sb_busy",  rd_busy_b,   32'd0);
    chk("r0_sb_busy0", rd_busy_b_0, 32'd0);

    // 4. scoreboard set / set-vs-clear / clear bypass
    sb_set = 1'b1; sb_addr = 5'd9; rd_addr_b = 5'd9;
    #1;
    chk("r9_set_same", rd_busy_b,   32'd0);
    cyc(); idle(); #1;
    chk("r9_busy",     rd_busy_b,   32'd1);
    chk("r9_busy0",    rd_busy_b_0, 32'd1);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; sb_set = 1'b1; sb_addr = 5'd9;
    #1;
    chk("r9_setwin_same",  rd_busy_b,   32'd1);
    chk("r9_setwin_same0", rd_busy_b_0, 32'd1);
    cyc(); idle(); #1;
    chk("r9_setwin",   rd_busy_b,   32'd1);
    chk("r9_setwin0",  rd_busy_b_0, 32'd1);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9A;
    #1;
    chk("r9_clr_byp",  rd_busy_b,   32'd0);
    chk("r9_clr_nob",  rd_busy_b_0, 32'd1);
    cyc(); idle(); #1;
    chk("r9_clr",      rd_busy_b,   32'd0);
    chk("r9_clr0",     rd_busy_b_0, 32'd0);
    chk("r9_data",     rd_data_b,   32'h9A);

    // 5. EPC port beats WB on the EPC register
    wr_en = 1'b1; wr_addr = 5'd26; wr_data = 32'h11;
    epc_en = 1'b1; epc_data = 32'h400; rd_addr_a = 5'd26;
    #1;
    chk("epc_byp",     rd_data_a,   32'h400);
    chk("epc_nobyp",   rd_data_a_0, 32'h0);
    chk("epc_q_same",  epc_q,       32'h0);
    cyc(); idle(); #1;
    chk("r26_epc",     rd_data_a,   32'h400);
    chk("r26_epc0",    rd_data_a_0, 32'h400);
    chk("epc_q",       epc_q,       32'h400);
    chk("epc_q0",      epc_q_0,     32'h400);

    // 6. reset mid-RUN wipes data and scoreboard; INIT-time traffic is dropped
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; sb_set = 1'b1; sb_addr = 5'd4;
    cyc(); idle();
    rd_addr_a = 5'd3; rd_addr_b = 5'd4;
    #1;
    chk("r3_pre",      rd_data_a,   32'h33);
    chk("r4_busy_pre", rd_busy_b,   32'd1);
    reset = 1'b1;
    #1;
    chk("rst_rd_blank", rd_data_a,  32'h0);
    cyc();
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
    sb_set = 1'b1; sb_addr = 5'd6;
    epc_en = 1'b1; epc_data = 32'h77;
    #1;
    sweep("reinit");
    chk("r3_wiped",    rd_data_a,   32'h0);
    chk("r4_busy_clr", rd_busy_b,   32'd0);
    rd_addr_a = 5'd29; rd_addr_b = 5'd6;
    #1;
    chk("r29_again",   rd_data_a,   32'h800);
    chk("r6_not_set",  rd_busy_b,   32'd0);
    rd_addr_a = 5'd5; rd_addr_b = 5'd26;
    #1;
    chk("r5_dropped",  rd_data_a,   32'h0);
    chk("r26_dropped", rd_data_b,   32'h0);
    chk("epc_q_wiped", epc_q,       32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
